// File: rtl/freelist_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | freelist_pkg                                                               |
// | Shared types and pointer helpers for the physical-register free list.      |
// | Revision: 2.0                                                              |
// +----------------------------------------------------------------------------+
package freelist_pkg;

    localparam int FL_NUM_PHYS_REGS    = 96;
    localparam int FL_CHECKPOINT_COUNT = 8;
    localparam int FL_PREG_W           = $clog2(FL_NUM_PHYS_REGS);
    localparam int FL_CKPT_W           = $clog2(FL_CHECKPOINT_COUNT);

    typedef logic [FL_PREG_W-1:0] preg_t;
    typedef logic [FL_CKPT_W-1:0] ckpt_id_t;

    // Modular add for any ring size; valid while p < n and k <= n.
    function automatic int unsigned wrap_add(input int unsigned p,
                                             input int unsigned k,
                                             input int unsigned n);
        int unsigned s;
        s = p + k;
        return (s >= n) ? (s - n) : s;
    endfunction

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 32; i++) begin
            c += 32'(v[i]);
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_compactor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lane_compactor                                                             |
// | Maps each valid lane to list index base+rank (mod N) and counts lanes.     |
// | Revision: 2.0                                                              |
// +----------------------------------------------------------------------------+
module lane_compactor
    import freelist_pkg::*;
#(
    parameter int  WIDTH = 4,
    parameter int  N     = 96,
    localparam int IW    = $clog2(N),
    localparam int RW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]    i_valid,
    input  logic [IW-1:0]       i_base,
    output logic [WIDTH*IW-1:0] o_idx,
    output logic [RW-1:0]       o_total
);

    always_comb begin
        int unsigned v_acc;
        v_acc = 0;
        o_idx = '0;
        // Rank of lane j is the number of valid lanes below it.
        for (int j = 0; j < WIDTH; j++) begin
            o_idx[j*IW +: IW] = IW'(wrap_add(32'(i_base), v_acc, N));
            v_acc += 32'(i_valid[j]);
        end
        o_total = RW'(popcount(32'(i_valid)));
    end

endmodule
`default_nettype wire

// File: rtl/phys_reg_freelist.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | phys_reg_freelist                                                          |
// | Circular free list of physical registers with head-only checkpoints.       |
// | Revision: 2.0                                                              |
// +----------------------------------------------------------------------------+
module phys_reg_freelist
    import freelist_pkg::*;
#(
    parameter int  NUM_PHYS_REGS    = 96,
    parameter int  NUM_ARCH_REGS    = 32,
    parameter int  ALLOC_WIDTH      = 4,
    parameter int  FREE_WIDTH       = 4,
    parameter int  CHECKPOINT_COUNT = 8,
    localparam int PREG_W           = $clog2(NUM_PHYS_REGS),
    localparam int CNT_W            = $clog2(NUM_PHYS_REGS + 1),
    localparam int CKPT_W           = $clog2(CHECKPOINT_COUNT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ALLOC_WIDTH-1:0]        alloc_req,
    output logic                          alloc_gnt,
    output logic [ALLOC_WIDTH*PREG_W-1:0] alloc_preg,
    input  logic [FREE_WIDTH-1:0]         free_req,
    input  logic [FREE_WIDTH*PREG_W-1:0]  free_preg,
    input  logic                          ckpt_save,
    output logic                          ckpt_ready,
    output logic [CKPT_W-1:0]             ckpt_id,
    input  logic                          ckpt_release,
    input  logic [CKPT_W-1:0]             ckpt_release_id,
    input  logic                          ckpt_restore,
    input  logic [CKPT_W-1:0]             ckpt_restore_id,
    input  logic [CHECKPOINT_COUNT-1:0]   ckpt_kill_mask,
    output logic [CNT_W-1:0]              free_count,
    output logic                          empty,
    output logic                          err
);

    localparam int INIT_FREE = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int AKW       = $clog2(ALLOC_WIDTH + 1);
    localparam int FKW       = $clog2(FREE_WIDTH + 1);

    logic [PREG_W-1:0]           r_list [NUM_PHYS_REGS];
    logic [PREG_W-1:0]           r_head;
    logic [PREG_W-1:0]           r_tail;
    logic [CNT_W-1:0]            r_count;
    logic [PREG_W-1:0]           r_ckpt_head [CHECKPOINT_COUNT];
    logic [CHECKPOINT_COUNT-1:0] r_ckpt_valid;
    logic                        r_err;

    logic [ALLOC_WIDTH*PREG_W-1:0] w_alloc_idx;
    logic [AKW-1:0]                w_alloc_k;
    logic [FREE_WIDTH-1:0]         w_free_ok;
    logic                          w_free_bad;
    logic [FREE_WIDTH*PREG_W-1:0]  w_free_idx;
    logic [FKW-1:0]                w_nfree;

    logic [PREG_W-1:0]           w_head_alloc;
    logic [PREG_W-1:0]           w_head_nxt;
    logic [PREG_W-1:0]           w_tail_nxt;
    logic [PREG_W-1:0]           w_restore_head;
    logic [CNT_W-1:0]            w_count_nxt;
    logic [CHECKPOINT_COUNT-1:0] w_valid_nxt;
    logic                        w_restore_ok;
    logic                        w_save_ok;
    logic                        w_err_nxt;

    lane_compactor #(.WIDTH(ALLOC_WIDTH), .N(NUM_PHYS_REGS)) u_alloc_cmp (
        .i_valid (alloc_req),
        .i_base  (r_head),
        .o_idx   (w_alloc_idx),
        .o_total (w_alloc_k)
    );

    lane_compactor #(.WIDTH(FREE_WIDTH), .N(NUM_PHYS_REGS)) u_free_cmp (
        .i_valid (w_free_ok),
        .i_base  (r_tail),
        .o_idx   (w_free_idx),
        .o_total (w_nfree)
    );

    // Out-of-range frees are dropped before compaction so they leave no hole.
    always_comb begin
        w_free_ok  = '0;
        w_free_bad = 1'b0;
        for (int j = 0; j < FREE_WIDTH; j++) begin
            if (free_req[j]) begin
                if (32'(free_preg[j*PREG_W +: PREG_W]) < NUM_PHYS_REGS) begin
                    w_free_ok[j] = 1'b1;
                end else begin
                    w_free_bad = 1'b1;
                end
            end
        end
    end

    assign alloc_gnt = (w_alloc_k != '0) && (r_count >= CNT_W'(w_alloc_k)) && !ckpt_restore;

    always_comb begin
        alloc_preg = '0;
        for (int j = 0; j < ALLOC_WIDTH; j++) begin
            if (alloc_gnt && alloc_req[j]) begin
                alloc_preg[j*PREG_W +: PREG_W] = r_list[w_alloc_idx[j*PREG_W +: PREG_W]];
            end
        end
    end

    always_comb begin
        ckpt_id = '0;
        for (int i = CHECKPOINT_COUNT - 1; i >= 0; i--) begin
            if (!r_ckpt_valid[i]) begin
                ckpt_id = CKPT_W'(i);
            end
        end
    end

    assign ckpt_ready = ~&r_ckpt_valid;
    assign free_count = r_count;
    assign empty      = (r_count == '0);
    assign err        = r_err;

    always_comb begin
        int unsigned v_cnt;
        w_head_alloc   = alloc_gnt ? PREG_W'(wrap_add(32'(r_head), 32'(w_alloc_k), NUM_PHYS_REGS))
                                   : r_head;
        w_tail_nxt     = PREG_W'(wrap_add(32'(r_tail), 32'(w_nfree), NUM_PHYS_REGS));
        w_restore_ok   = ckpt_restore && (32'(ckpt_restore_id) < CHECKPOINT_COUNT)
                         && r_ckpt_valid[ckpt_restore_id];
        w_restore_head = r_ckpt_head[ckpt_restore_id];
        w_save_ok      = ckpt_save && ckpt_ready && !ckpt_restore;
        w_err_nxt      = r_err | w_free_bad
                         | (ckpt_save && !ckpt_ready && !ckpt_restore)
                         | (ckpt_restore && !w_restore_ok);
        w_head_nxt     = r_head;
        w_valid_nxt    = r_ckpt_valid;
        v_cnt          = 32'(r_count) - (alloc_gnt ? 32'(w_alloc_k) : 32'd0) + 32'(w_nfree);

        if (ckpt_restore) begin
            if (w_restore_ok) begin
                w_head_nxt  = w_restore_head;
                w_valid_nxt = r_ckpt_valid & ~ckpt_kill_mask;
                w_valid_nxt[ckpt_restore_id] = 1'b0;
                // Frees landing this cycle stay in the list; only head rolls back.
                v_cnt = (32'(w_tail_nxt) >= 32'(w_restore_head))
                        ? 32'(w_tail_nxt) - 32'(w_restore_head)
                        : 32'(w_tail_nxt) + NUM_PHYS_REGS - 32'(w_restore_head);
            end
        end else begin
            w_head_nxt = w_head_alloc;
            if (ckpt_release && (32'(ckpt_release_id) < CHECKPOINT_COUNT)) begin
                w_valid_nxt[ckpt_release_id] = 1'b0;
            end
            if (w_save_ok) begin
                w_valid_nxt[ckpt_id] = 1'b1;
            end
        end

        if (v_cnt > INIT_FREE) begin
            v_cnt     = INIT_FREE;
            w_err_nxt = 1'b1;
        end
        w_count_nxt = CNT_W'(v_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PHYS_REGS; i++) begin
                r_list[i] <= (i < INIT_FREE) ? PREG_W'(NUM_ARCH_REGS + i) : '0;
            end
            r_head       <= '0;
            r_tail       <= PREG_W'(INIT_FREE);
            r_count      <= CNT_W'(INIT_FREE);
            r_ckpt_valid <= '0;
            r_err        <= 1'b0;
        end else begin
            for (int j = 0; j < FREE_WIDTH; j++) begin
                if (w_free_ok[j]) begin
                    r_list[w_free_idx[j*PREG_W +: PREG_W]] <= free_preg[j*PREG_W +: PREG_W];
                end
            end
            r_head       <= w_head_nxt;
            r_tail       <= w_tail_nxt;
            r_count      <= w_count_nxt;
            r_ckpt_valid <= w_valid_nxt;
            r_err        <= w_err_nxt;
        end
    end

    // Slot contents only matter while the valid bit is set, so no reset here.
    always_ff @(posedge clk) begin
        if (!rst && w_save_ok) begin
            r_ckpt_head[ckpt_id] <= w_head_alloc;
        end
    end

endmodule
`default_nettype wire

// File: doc/phys_reg_freelist.md
# phys_reg_freelist

Second-generation physical-register free list for the rename stage. It is a circular FIFO of free physical register numbers. Depth is any integer, so non-power-of-two register files such as 96 entries are supported. Rename allocation is all-or-nothing per group, commit returns registers, and up to CHECKPOINT_COUNT internally allocated head checkpoints support branch recovery. Commit-time frees are never lost across a restore, because only the head pointer is rolled back.

## Interface
- NUM_PHYS_REGS, 96: physical registers; any value > NUM_ARCH_REGS.
- NUM_ARCH_REGS, 32: registers mapped at reset (p0..p31).
- ALLOC_WIDTH, 4: rename lanes per cycle.
- FREE_WIDTH, 4: commit free lanes per cycle.
- CHECKPOINT_COUNT, 8: checkpoint slots, ≥2.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- alloc_req  in  ALLOC_WIDTH  per-lane destination request.
- alloc_gnt  out  1  whole group granted this cycle.
- alloc_preg  out  ALLOC_WIDTH×PREG_W  register per lane; 0 for unrequested lanes or when not granted.
- free_req  in  FREE_WIDTH  per-lane free valid; may be sparse.
- free_preg  in  FREE_WIDTH×PREG_W  registers returned at commit.
- ckpt_save  in  1  take a checkpoint of the post-allocation head.
- ckpt_ready  out  1  at least one slot is invalid.
- ckpt_id  out  CKPT_W  slot used by a save this cycle: the lowest invalid slot.
- ckpt_release  in  1  invalidate slot ckpt_release_id (branch resolved correct).
- ckpt_release_id  in  CKPT_W.
- ckpt_restore  in  1  roll back to slot ckpt_restore_id.
- ckpt_restore_id  in  CKPT_W.
- ckpt_kill_mask  in  CHECKPOINT_COUNT  younger slots to invalidate on restore.
- free_count  out  CNT_W  free registers currently in the list.
- empty  out  1  free_count==0.
- err  out  1  sticky protocol error.

## Operation
- Widths: PREG_W=$clog2(NUM_PHYS_REGS), CNT_W=$clog2(NUM_PHYS_REGS+1), CKPT_W=$clog2(CHECKPOINT_COUNT).
- All pointer arithmetic is wrap_add(p,k) = (p+k ≥ N) ? p+k−N : p+k, with k ≤ max(ALLOC_WIDTH,FREE_WIDTH). No % operator and no power-of-two assumption.
- Reset:
  - list[i]=NUM_ARCH_REGS+i for i < N−A; other entries 0.
  - head=0, tail=wrap(N−A), count=N−A.
  - All checkpoint slots invalid, err=0.
  - Output reset values: alloc_gnt=0, alloc_preg all 0, ckpt_ready=1, ckpt_id=0, free_count=N−A, empty=0, err=0.
- Invariant: count = (tail−head) mod N. count ≤ N−A < N, so head==tail always means empty.
- Allocation:
  - Let k=popcount(alloc_req).
  - alloc_gnt = (k≠0) && (count ≥ k) && !ckpt_restore.
  - When granted, requested lane j receives list[wrap(head, rank_j)], where rank_j is the number of requested lanes below j.
  - head advances by k. There is no partial grant.
- Free:
  - Valid lanes are compacted and written at tail, tail+1, …; tail advances by popcount(free_req).
  - Frees are applied every non-reset cycle, including restore cycles.
  - Same-cycle frees are not visible to allocation; there is no bypass.
- count_next = count − (gnt?k:0) + nfree, or the restore value below.
- Save:
  - Accepted only if ckpt_ready && !ckpt_restore.
  - Writes slot ckpt_id with the head after this cycle's grant and marks the slot valid.
  - A save with !ckpt_ready sets err and is ignored.
- Release: clears the valid bit. If save and release target the same slot in one cycle, the save wins.
- Restore:
  - head ← slot head; count ← (tail_next − slot head) mod N.
  - Invalidates the restored slot and every slot in ckpt_kill_mask.
  - Same-cycle save and release are ignored.
  - Restoring an invalid slot sets err and changes nothing except that frees still apply.
- err is also set by:
  - a free with preg ≥ N; that lane is dropped;
  - count_next > N−A; the count is saturated.

## Timing
- alloc_preg and alloc_gnt are combinational from registered head, count and list, and from alloc_req. Zero-cycle response; state updates at the next clock edge.
- A freed register can be allocated at the earliest one cycle after its free_req.
- Restore takes effect at the next edge. Allocation resumes the cycle after restore.
- free_count, empty, ckpt_ready and ckpt_id are registered-state derived (no input dependence).
- rst asserted mid-operation discards everything at that edge and overrides all other inputs.

## Structure
- Package freelist_pkg holds:
  - preg_t and ckpt_id_t typedefs, parameterised by localparams;
  - the wrap_add function;
  - the popcount function.
- One sub-module, lane_compactor #(WIDTH, N): takes a valid vector and outputs a rank per lane plus a total. It is instantiated twice, once for alloc and once for free.
- Checkpoint storage is a head-pointer array plus a valid vector; there is no tail or count storage.

## Test plan
- After reset, N=96, A=32: alloc_req=4'b1111 → gnt=1, pregs 32,33,34,35; next cycle free_count=60.
- alloc_req=4'b1010 with count=1 → gnt=0, head unchanged. Then free_req=4'b0101 (p5,p7) → next cycle count=3, list tail holds 5 then 7.
- Wrap: drive head to 94 with count=4, then allocate 4 → indices 94,95,0,1; head=2, no out-of-range index.
- Save the checkpoint with 2 allocations in the same cycle. Allocate 6 more and free 3 during the restore cycle → head equals the saved post-alloc head; count = saved count + 3; slot invalid; ckpt_kill_mask slots invalid.
- Fill all 8 slots → ckpt_ready=0; a 9th save → err=1 and slots unchanged. Release slot 3 → ckpt_id=3.
- Free preg 100 with N=96 → err=1, count unchanged. Assert rst mid-burst → next cycle matches reset state.
